// File: rtl/shark_sprite_engine_pkg.sv
// shark_sprite_engine_pkg: shared constants for the shark/collectable sprite pipeline
package shark_sprite_engine_pkg;
  localparam logic [11:0] SPRITE_KEY        = 12'h000;
  localparam int          SPRITE_W          = 40;
  localparam int          SPRITE_H          = 20;
  localparam int          SPRITE_LOG_FRAMES = 3;
  localparam int          SPRITE_PERIOD     = 8;
  typedef enum logic [2:0] {
    S_SHARK = 3'd0,
    S_COIN  = 3'd1
  } s_type_e;
endpackage

// File: rtl/shark_sprite_engine_anim_counter.sv
// sprite_anim_counter: vsync edge detect, period counter and animation frame index
module sprite_anim_counter
  import shark_sprite_engine_pkg::*;
#(
  parameter int LOG_FRAMES   = SPRITE_LOG_FRAMES,
  parameter int FRAME_PERIOD = SPRITE_PERIOD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  enable,
  output logic                  fb,
  output logic [LOG_FRAMES-1:0] frame
);
  localparam int CW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  logic                  r_vsync_d;
  logic [CW-1:0]         r_cnt;
  logic [LOG_FRAMES-1:0] r_frame;
  logic                  w_wrap;
  assign fb     = vsync & ~r_vsync_d;
  assign w_wrap = (r_cnt == CW'(FRAME_PERIOD - 1));
  assign frame  = r_frame;
  // count enabled frame boundaries; each full period steps the frame index, which wraps by width
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_vsync_d <= 1'b0;
      r_cnt     <= '0;
      r_frame   <= '0;
    end else begin
      r_vsync_d <= vsync;
      if (fb && enable) begin
        r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
        r_frame <= w_wrap ? r_frame + 1'b1 : r_frame;
      end
    end
endmodule

// File: rtl/shark_sprite_engine.sv
// shark_sprite_engine: sprite box hit test, ROM addressing and keyed pixel output
module shark_sprite_engine
  import shark_sprite_engine_pkg::*;
#(
  parameter int          WIDTH        = SPRITE_W,
  parameter int          HEIGHT       = SPRITE_H,
  parameter int          LOG_FRAMES   = SPRITE_LOG_FRAMES,
  parameter int          FRAME_PERIOD = SPRITE_PERIOD,
  parameter logic [11:0] TRANSPARENT  = SPRITE_KEY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  input  logic                  vsync,
  input  logic                  enable,
  input  logic [10:0]           sprite_x,
  input  logic [9:0]            sprite_y,
  input  logic [2:0]            s_type_in,
  output logic [5:0]            rom_x,
  output logic [4:0]            rom_y,
  output logic [2:0]            rom_s_type,
  output logic [LOG_FRAMES-1:0] rom_frame,
  input  logic [11:0]           rom_pixel,
  output logic [11:0]           pixel_out,
  output logic                  pixel_valid
);
  logic        w_fb, w_hit, w_opaque;
  logic [11:0] w_hend;
  logic [10:0] w_vend;
  logic [10:0] r_px;
  logic [9:0]  r_py;
  logic [2:0]  r_ptype;
  logic        r_latched_ok;
  logic [5:0]  r_rom_x;
  logic [4:0]  r_rom_y;
  logic [2:0]  r_rom_s_type;
  logic        r_hit1;
  logic [11:0] r_pixel_out;
  logic        r_pixel_valid;
  sprite_anim_counter #(
    .LOG_FRAMES  (LOG_FRAMES),
    .FRAME_PERIOD(FRAME_PERIOD)
  ) u_anim (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .enable(enable),
    .fb    (w_fb),
    .frame (rom_frame)
  );
  // box ends are one bit wider so a sprite at the right/bottom edge never wraps to column/row 0
  assign w_hend   = {1'b0, r_px} + 12'(WIDTH);
  assign w_vend   = {1'b0, r_py} + 11'(HEIGHT);
  assign w_hit    = enable & r_latched_ok & (hcount >= r_px) & ({1'b0, hcount} < w_hend)
                  & (vcount >= r_py) & ({1'b0, vcount} < w_vend);
  assign w_opaque = r_hit1 & (rom_pixel != TRANSPARENT);
  assign rom_x       = r_rom_x;
  assign rom_y       = r_rom_y;
  assign rom_s_type  = r_rom_s_type;
  assign pixel_out   = r_pixel_out;
  assign pixel_valid = r_pixel_valid;
  // position/type latch at the frame boundary; latched_ok blocks drawing until the first load
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_px         <= '0;
      r_py         <= '0;
      r_ptype      <= '0;
      r_latched_ok <= 1'b0;
    end else if (w_fb) begin
      r_px         <= sprite_x;
      r_py         <= sprite_y;
      r_ptype      <= s_type_in;
      r_latched_ok <= 1'b1;
    end
  // stage 1: hit test and ROM address, zero address outside the box
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rom_x      <= '0;
      r_rom_y      <= '0;
      r_rom_s_type <= '0;
      r_hit1       <= 1'b0;
    end else begin
      r_rom_x      <= w_hit ? 6'(hcount - r_px) : '0;
      r_rom_y      <= w_hit ? 5'(vcount - r_py) : '0;
      r_rom_s_type <= r_ptype;
      r_hit1       <= w_hit;
    end
  // stage 2: colour-key the ROM pixel
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pixel_out   <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_pixel_out   <= w_opaque ? rom_pixel : '0;
      r_pixel_valid <= w_opaque;
    end
endmodule

// File: doc/shark_sprite_engine.md
Name: shark_sprite_engine

Overview:
- Per-pixel addressing and animation stage that sits directly upstream of the shark/collectable sprite ROM.
- Each cycle it takes the XVGA scan position and decides whether the position falls inside the sprite box.
- When it does, it drives the ROM's x/y/s_type/frame inputs and registers the returned 12-bit pixel.
- It advances the animation frame on vsync and outputs a keyed pixel plus an opaque flag for the display mixer.

Parameters:
- WIDTH, 40: sprite width in pixels; ROM x range 0..WIDTH-1.
- HEIGHT, 20: sprite height in lines; ROM y range 0..HEIGHT-1.
- LOG_FRAMES, 3: width of the animation frame index.
- FRAME_PERIOD, 8: number of vsync rising edges per animation step; must be ≥1.
- TRANSPARENT, 12'h000: colour key treated as transparent.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- hcount  in  11  current horizontal scan position.
- vcount  in  10  current vertical scan position.
- vsync  in  1  active-high frame sync; the rising edge marks the frame boundary.
- enable  in  1  sprite shown and animated when high.
- sprite_x  in  11  left edge of the sprite, sampled at the frame boundary.
- sprite_y  in  10  top edge of the sprite, sampled at the frame boundary.
- s_type_in  in  3  sprite type, sampled at the frame boundary.
- rom_x  out  6  column address to the ROM.
- rom_y  out  5  row address to the ROM.
- rom_s_type  out  3  latched type to the ROM.
- rom_frame  out  LOG_FRAMES  animation index to the ROM.
- rom_pixel  in  12  combinational ROM output for the current rom_x/rom_y.
- pixel_out  out  12  keyed sprite pixel; 0 when not opaque.
- pixel_valid  out  1  high when the sprite is opaque at this pixel.

Behaviour:
- Reset (async): all outputs and internal registers go to 0, including the latched position/type, frame counter, vsync period counter, pipeline valid bits and vsync_d.
- Frame boundary (fb):
  - vsync_d is a registered copy of vsync; fb = vsync & ~vsync_d.
  - On fb, latch sprite_x, sprite_y and s_type_in into px, py, ptype.
  - Between fb events the latches hold, so a mid-frame position change has no visible effect.
- Animation:
  - On fb with enable=1, the period counter increments.
  - When the counter reaches FRAME_PERIOD-1 it clears and rom_frame increments modulo 2^LOG_FRAMES (7 -> 0).
  - With enable=0, both the counter and rom_frame hold.
- Stage 1 (registered, 1 cycle):
  - hit = enable & (hcount ≥ px) & (hcount < px+WIDTH) & (vcount ≥ py) & (vcount < py+HEIGHT).
  - Sums are computed one bit wider than the operands so a sprite at the right or bottom edge does not wrap.
  - rom_x <= hit ? hcount-px : 0; rom_y <= hit ? vcount-py : 0; hit1 <= hit; rom_s_type <= ptype.
- ROM: combinational, returns rom_pixel in the same cycle as rom_x/rom_y.
- Stage 2 (registered):
  - opaque = hit1 & (rom_pixel != TRANSPARENT).
  - pixel_valid <= opaque; pixel_out <= opaque ? rom_pixel : 0.
- Latency: exactly 2 clk from an hcount/vcount sample to the corresponding pixel_out/pixel_valid. Downstream delays its own hcount by 2 to match.
- Boundaries:
  - hcount = px+WIDTH-1 is a hit; px+WIDTH is a miss. The same rule applies vertically.
  - px+WIDTH > 1023 is allowed; columns beyond the display are simply never scanned.
  - fb coincident with an in-box pixel: that pixel uses the old latches; latches update on the next edge.
  - enable deassert: takes effect at stage 1 on the next edge. Data already in the pipeline still drains and is output.
  - Reset asserted mid-frame: outputs are 0 immediately. After release, nothing is drawn until the next fb loads the latches, because the zeroed latches with WIDTH>0 would otherwise place the sprite at the top-left corner. To enforce this, a latched_ok flag is cleared by reset, set by the first fb, and ANDed into hit.

Decomposition:
- Shared constants header: TRANSPARENT key, SPRITE_W/SPRITE_H, LOG_FRAMES, s_type code for the coin collectable (1).
- One natural sub-module: sprite_anim_counter, covering vsync edge detect, the period counter and the frame index. It outputs fb and frame.

Test Plan:
- Reset, then one vsync pulse with sprite_x=100, sprite_y=50, enable=1. Scan hcount=100, vcount=50 -> rom_x=0, rom_y=0 after 1 clk. With rom_pixel=12'h688 modelled, pixel_out=12'h688 and pixel_valid=1 after 2 clk.
- Same setup with hcount=139 -> rom_x=39 and a hit. hcount=140 or vcount=70 -> pixel_valid=0 and pixel_out=0.
- In-box pixel with rom_pixel=12'h000 -> pixel_valid=0, pixel_out=0.
- FRAME_PERIOD=8: after 8 fb events rom_frame=1; after 64, rom_frame=0 (wrap from 7). With enable=0 during 8 fb events, rom_frame is unchanged.
- Change sprite_x from 100 to 300 mid-frame -> hcount=100 still hits until the next vsync rising edge; afterwards hcount=300 hits.
- Assert reset mid-scan at an in-box pixel -> pixel_valid=0 immediately and rom_frame=0. No hit occurs until the first fb after release. sprite_x=1000 produces no wrap hit at hcount=0..39.
